// File: rtl/fetch_decode_queue.sv
// In-order instruction buffer between fetch and decode.
// The head entry is held in an output register so that no input reaches an output combinationally.
module fetch_decode_queue #(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 40,
  parameter int CAUSE_W = 6
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [ADDR_W-1:0]        pc_i,
  input  logic [31:0]              inst_i,
  input  logic                     ex_valid_i,
  input  logic [CAUSE_W-1:0]       ex_cause_i,
  input  logic                     bpred_taken_i,
  input  logic [ADDR_W-1:0]        bpred_addr_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [ADDR_W-1:0]        pc_o,
  output logic [31:0]              inst_o,
  output logic                     ex_valid_o,
  output logic [CAUSE_W-1:0]       ex_cause_o,
  output logic                     bpred_taken_o,
  output logic [ADDR_W-1:0]        bpred_addr_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + 32 + 1 + CAUSE_W + 1 + ADDR_W;

  typedef enum logic {RUN, EXC_HOLD} state_t;

  state_t              state_reg, state_next;
  logic [PTR_W-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]    count_reg, count_next;
  logic [ENT_W-1:0]    head_reg, head_next;
  logic [ENT_W-1:0]    mem [DEPTH];
  logic [ENT_W-1:0]    in_entry;
  logic                push, pop;

  assign in_entry = {pc_i, inst_i, ex_valid_i, ex_cause_i, bpred_taken_i, bpred_addr_i};

  assign ready_o = (state_reg == RUN) && (count_reg != CNT_W'(DEPTH));
  assign valid_o = (count_reg != '0);
  assign push    = valid_i && ready_o;
  assign pop     = valid_o && ready_i;
  assign count_o = count_reg;

  assign {pc_o, inst_o, ex_valid_o, ex_cause_o, bpred_taken_o, bpred_addr_o} = head_reg;

  // Pointer / occupancy update; flush overrides any push or pop in the same cycle.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush_i) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Next head: bypass the incoming entry when it lands exactly on the new read slot.
  always_comb begin
    head_next = head_reg;
    if (!flush_i && (count_next != '0)) begin
      if (push && (wr_ptr_reg == rd_ptr_next))
        head_next = in_entry;
      else
        head_next = mem[rd_ptr_next];
    end
  end

  always_comb begin
    state_next = state_reg;
    if (flush_i)
      state_next = RUN;
    else if ((state_reg == RUN) && push && ex_valid_i)
      state_next = EXC_HOLD;
  end

  always_ff @(posedge clk_i) begin
    if (push && !flush_i)
      mem[wr_ptr_reg] <= in_entry;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg  <= RUN;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      head_reg   <= head_next;
    end
  end

endmodule
